// File: rtl/periph_timer.sv
// rtl/periph_timer.sv - memory-mapped reload timer with LED/switch port and interrupt
// Optional free-running SYSTICK counter built only when PERIPH_TIMER_SYSTICK_EN is defined.
module periph_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic        irqout
);

  localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

  logic        sel;
  logic [2:0]  reg_idx;
  logic        th_we, tl_we, tcon_we, led_we;
  logic [31:0] th, tl;
  logic        run, irq_en, irq_st;
  logic [7:0]  led_q, sw_meta, sw_sync;
  logic [31:0] systick;
  logic        overflow;

  assign sel     = (addr[31:5] == BASE_ADDR[31:5]) && (addr[1:0] == 2'b00);
  assign reg_idx = addr[4:2];
  assign th_we   = wr && sel && (reg_idx == 3'd0);
  assign tl_we   = wr && sel && (reg_idx == 3'd1);
  assign tcon_we = wr && sel && (reg_idx == 3'd2);
  assign led_we  = wr && sel && (reg_idx == 3'd3);

  // A bus write to TL suppresses both the increment and the overflow event.
  assign overflow = run && (tl == TL_MAX) && !tl_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th      <= '0;
      tl      <= '0;
      run     <= 1'b0;
      irq_en  <= 1'b0;
      irq_st  <= 1'b0;
      led_q   <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
      if (th_we)  th    <= wdata;
      if (led_we) led_q <= wdata[7:0];
      if (tl_we)
        tl <= wdata;
      else if (overflow)
        tl <= th;
      else if (run)
        tl <= tl + 32'd1;
      if (tcon_we) begin
        run    <= wdata[0];
        irq_en <= wdata[1];
      end
      // Overflow set takes priority over a simultaneous write-1-to-clear.
      if (overflow && irq_en)
        irq_st <= 1'b1;
      else if (tcon_we && wdata[2])
        irq_st <= 1'b0;
    end
  end

`ifdef PERIPH_TIMER_SYSTICK_EN
  logic [31:0] systick_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) systick_q <= '0;
    else        systick_q <= systick_q + 32'd1;
  end
  assign systick = systick_q;
`else
  assign systick = '0;
`endif

  always_comb begin
    rdata = '0;
    if (rd && sel) begin
      case (reg_idx)
        3'd0:    rdata = th;
        3'd1:    rdata = tl;
        3'd2:    rdata = {29'd0, irq_st, irq_en, run};
        3'd3:    rdata = {24'd0, led_q};
        3'd4:    rdata = {24'd0, sw_sync};
        3'd5:    rdata = systick;
        default: rdata = '0;
      endcase
    end
  end

  assign led    = led_q;
  assign irqout = irq_en & irq_st;

endmodule

// File: tb/tb_periph_timer.sv
// tb/tb_periph_timer.sv - vector table, directed corner sequences and randomized model check for periph_timer
module tb_periph_timer;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  switch, led;
  logic        irqout;

  int n_cmp = 0;
  int n_bad = 0;

  periph_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .switch(switch), .led(led), .irqout(irqout)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_th, m_tl, m_tick;
  logic        m_run, m_ie, m_st;
  logic [7:0]  m_led;
  logic [7:0]  m_hist[$];

  task automatic model_reset();
    m_th = 0; m_tl = 0; m_tick = 0; m_run = 0; m_ie = 0; m_st = 0; m_led = 0;
    m_hist = '{8'h00, 8'h00};
  endtask

  function automatic int m_index(input logic [31:0] a);
    if ((a >> 5) != (BASE >> 5) || (a % 4) != 0) return -1;
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (m_index(a))
      0: return m_th;
      1: return m_tl;
      2: return {29'd0, m_st, m_ie, m_run};
      3: return {24'd0, m_led};
      4: return {24'd0, m_hist[0]};
`ifdef PERIPH_TIMER_SYSTICK_EN
      5: return m_tick;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    rd = 1'b1; addr = a;
    #1;
    chk(nm, rdata, exp);
    rd = 1'b0;
  endtask

  // One clock with optional write; the model advances by the rules of the register map.
  task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
    int idx;
    logic [32:0] sum;
    logic tl_we, ovf;
    logic [31:0] n_th, n_tl;
    logic n_run, n_ie, n_st;
    logic [7:0] n_led;
    wr = w; addr = a; wdata = d; switch = s;
    idx = w ? m_index(a) : -1;
    tl_we = (idx == 1);
    sum = {1'b0, m_tl} + 33'd1;
    ovf = m_run && sum[32] && !tl_we;
    n_tl = tl_we ? d : (!m_run ? m_tl : (sum[32] ? m_th : sum[31:0]));
    n_th = (idx == 0) ? d : m_th;
    n_led = (idx == 3) ? d[7:0] : m_led;
    n_run = (idx == 2) ? d[0] : m_run;
    n_ie = (idx == 2) ? d[1] : m_ie;
    n_st = (ovf && m_ie) ? 1'b1 : ((idx == 2 && d[2]) ? 1'b0 : m_st);
    @(posedge clk);
    #1;
    m_th = n_th; m_tl = n_tl; m_led = n_led; m_run = n_run; m_ie = n_ie; m_st = n_st;
    m_hist.push_back(s);
    void'(m_hist.pop_front());
    m_tick = m_tick + 1;
    wr = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] waddr;
    logic [31:0] wd;
    logic [7:0]  sw;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_led;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] a, d, exp_tick;
    logic [7:0] s;
    int r;

    vecs[0]  = '{1, BASE + 32'h00, 32'hFFFF_FFF0, 8'h00, BASE + 32'h00, 32'hFFFF_FFF0, 8'h00, 0};
    vecs[1]  = '{1, BASE + 32'h04, 32'hFFFF_FFFC, 8'h00, BASE + 32'h04, 32'hFFFF_FFFC, 8'h00, 0};
    vecs[2]  = '{1, BASE + 32'h08, 32'h0000_0003, 8'h00, BASE + 32'h08, 32'h0000_0003, 8'h00, 0};
    vecs[3]  = '{0, 32'h0,         32'h0,         8'h00, BASE + 32'h04, 32'hFFFF_FFFD, 8'h00, 0};
    vecs[4]  = '{0, 32'h0,         32'h0,         8'h00, BASE + 32'h04, 32'hFFFF_FFFE, 8'h00, 0};
    vecs[5]  = '{0, 32'h0,         32'h0,         8'h00, BASE + 32'h04, 32'hFFFF_FFFF, 8'h00, 0};
    vecs[6]  = '{0, 32'h0,         32'h0,         8'h00, BASE + 32'h04, 32'hFFFF_FFF0, 8'h00, 1};
    vecs[7]  = '{0, 32'h0,         32'h0,         8'h00, BASE + 32'h08, 32'h0000_0007, 8'h00, 1};
    vecs[8]  = '{1, BASE + 32'h08, 32'h0000_0007, 8'h00, BASE + 32'h08, 32'h0000_0003, 8'h00, 0};
    vecs[9]  = '{1, BASE + 32'h0C, 32'h0000_01A5, 8'h3C, BASE + 32'h0C, 32'h0000_00A5, 8'hA5, 0};
    vecs[10] = '{0, 32'h0,         32'h0,         8'h3C, BASE + 32'h10, 32'h0000_003C, 8'hA5, 0};
    vecs[11] = '{1, BASE + 32'h18, 32'hFFFF_FFFF, 8'h3C, BASE + 32'h18, 32'h0000_0000, 8'hA5, 0};
    vecs[12] = '{1, BASE + 32'h10, 32'h0000_0000, 8'h3C, BASE + 32'h10, 32'h0000_003C, 8'hA5, 0};
    vecs[13] = '{1, BASE + 32'h0D, 32'h0000_0000, 8'h3C, BASE + 32'h0C, 32'h0000_00A5, 8'hA5, 0};
    vecs[14] = '{1, 32'h5000_000C, 32'h0000_0000, 8'h3C, BASE + 32'h0C, 32'h0000_00A5, 8'hA5, 0};
    vecs[15] = '{1, BASE + 32'h14, 32'h0000_1234, 8'h3C, BASE + 32'h04, 32'hFFFF_FFF9, 8'hA5, 0};

    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; switch = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_led", {24'd0, led}, 32'h0);
    chk("reset_irq", {31'd0, irqout}, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) rd_chk($sformatf("reset_reg%0d", i), BASE + 32'(4 * i), 32'h0);

    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].w, vecs[i].waddr, vecs[i].wd, vecs[i].sw);
      rd_chk($sformatf("vec%0d_rdata", i), vecs[i].raddr, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, vecs[i].exp_led});
      chk($sformatf("vec%0d_irq", i), {31'd0, irqout}, {31'd0, vecs[i].exp_irq});
    end

    // W1C in the same cycle as an overflow: set wins
    cycle(1, BASE + 32'h04, 32'hFFFF_FFFF, 8'h3C);
    cycle(1, BASE + 32'h08, 32'h0000_0007, 8'h3C);
    rd_chk("w1c_vs_ovf_tcon", BASE + 32'h08, 32'h7);
    chk("w1c_vs_ovf_irq", {31'd0, irqout}, 32'h1);

    // Wrap with irq disabled: reload, no status
    cycle(1, BASE + 32'h08, 32'h0000_0005, 8'h3C);
    rd_chk("noirq_tcon_a", BASE + 32'h08, 32'h1);
    cycle(1, BASE + 32'h04, 32'hFFFF_FFFF, 8'h3C);
    cycle(0, 32'h0, 32'h0, 8'h3C);
    rd_chk("noirq_tl", BASE + 32'h04, 32'hFFFF_FFF0);
    rd_chk("noirq_tcon_b", BASE + 32'h08, 32'h1);
    chk("noirq_irq", {31'd0, irqout}, 32'h0);

    // TH written in the reload cycle: reload uses old TH
    cycle(1, BASE + 32'h04, 32'hFFFF_FFFF, 8'h3C);
    cycle(1, BASE + 32'h00, 32'h0000_1234, 8'h3C);
    rd_chk("th_race_tl", BASE + 32'h04, 32'hFFFF_FFF0);
    rd_chk("th_race_th", BASE + 32'h00, 32'h0000_1234);

    // TL write at TL=max wins, no overflow event
    cycle(1, BASE + 32'h08, 32'h0000_0003, 8'h3C);
    cycle(1, BASE + 32'h04, 32'hFFFF_FFFF, 8'h3C);
    cycle(1, BASE + 32'h04, 32'h0000_0005, 8'h3C);
    rd_chk("tl_wr_wins_tl", BASE + 32'h04, 32'h5);
    rd_chk("tl_wr_wins_tcon", BASE + 32'h08, 32'h3);

    // Stop freezes TL and keeps status
    cycle(1, BASE + 32'h04, 32'hFFFF_FFFF, 8'h3C);
    cycle(0, 32'h0, 32'h0, 8'h3C);
    cycle(1, BASE + 32'h08, 32'h0000_0002, 8'h3C);
    repeat (3) cycle(0, 32'h0, 32'h0, 8'h3C);
    rd_chk("freeze_tl", BASE + 32'h04, 32'h0000_1235);
    rd_chk("freeze_tcon", BASE + 32'h08, 32'h6);

    // Reset mid-count with irq pending
    cycle(1, BASE + 32'h08, 32'h0000_0003, 8'h3C);
    cycle(0, 32'h0, 32'h0, 8'h3C);
    chk("pre_reset_irq", {31'd0, irqout}, 32'h1);
    #3 reset = 1'b0;
    #1;
    chk("midreset_led", {24'd0, led}, 32'h0);
    chk("midreset_irq", {31'd0, irqout}, 32'h0);
    rd_chk("midreset_systick", BASE + 32'h14, 32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) cycle(0, 32'h0, 32'h0, 8'h3C);
    rd_chk("post_reset_tl", BASE + 32'h04, 32'h0);
    rd_chk("post_reset_tcon", BASE + 32'h08, 32'h0);
`ifdef PERIPH_TIMER_SYSTICK_EN
    exp_tick = 32'd3;
`else
    exp_tick = 32'd0;
`endif
    rd_chk("post_reset_systick", BASE + 32'h14, exp_tick);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = BASE + 32'(4 * r);
      else if (r == 8) a = BASE + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(1, 3));
      else             a = (BASE ^ 32'h0010_0000) + 32'(4 * $urandom_range(0, 7));
      d = $urandom;
      if (a == BASE + 32'h04 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      if (a == BASE + 32'h08 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      s = 8'($urandom);
      cycle($urandom_range(0, 9) < 4, a, d, s);
      chk("rand_led", {24'd0, led}, {24'd0, m_led});
      chk("rand_irq", {31'd0, irqout}, {31'd0, m_ie & m_st});
      for (int k = 0; k < 2; k++) begin
        a = (k == 0) ? BASE + 32'(4 * $urandom_range(0, 7)) : BASE + 32'($urandom_range(0, 31));
        if ($urandom_range(0, 7) == 0) begin
          rd = 1'b0; addr = a; #1;
          chk("rand_rd_idle", rdata, 32'h0);
        end else begin
          rd_chk("rand_read", a, m_read(a));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
